rv32i_imm_encoder: RTL and testbench

Two-stage pipelined RV32I instruction encoder: the inverse of the immediate generator in the decode path. It accepts a decoded field set (type select, register indices, funct fields and a full 32-bit immediate value) over a valid/ready handshake. It range-checks the immediate for the selected format and scatters its bits into the architectural instruction word. It sits in the test/boot path, feeding instruction memory loaders and self-check benches that round-trip words through the decoder.

---
 rtl/rv32i_imm_encoder.sv | 177 +++++++++++++++++
 tb/tb_rv32i_imm_encoder.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_imm_encoder.sv
// RV32I instruction encoder: takes a decoded field set plus a sign-extended immediate,
// range-checks the immediate for the selected format and packs the architectural word.
module rv32i_imm_encoder #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        I_type_en,
    input  logic        L_type_en,
    input  logic        S_type_en,
    input  logic        B_type_en,
    input  logic        J_type_en,
    input  logic        U_type_en,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] instr_count,
    output logic [15:0] err_count
);

    localparam int SEL_I = 0;
    localparam int SEL_L = 1;
    localparam int SEL_S = 2;
    localparam int SEL_B = 3;
    localparam int SEL_J = 4;
    localparam int SEL_U = 5;

    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_B = 7'b1100011;
    localparam logic [6:0] OP_J = 7'b1101111;
    localparam logic [6:0] OP_U = 7'b0110111;

    function automatic logic is_shift(input logic [5:0] sel, input logic [2:0] f3);
        return sel[SEL_I] && (f3 == 3'b001 || f3 == 3'b101);
    endfunction

    // Priority: bad select, then misalignment, then range.
    function automatic logic [1:0] check_fields(input logic [5:0] sel, input logic [2:0] f3,
                                                input logic [31:0] imm);
        logic signed [31:0] v;
        logic signed [31:0] lo;
        logic signed [31:0] hi;
        logic [1:0]         code;
        v    = imm;
        lo   = -32'sd2048;
        hi   = 32'sd2047;
        code = 2'd0;
        if (sel[SEL_B]) begin
            lo = -32'sd4096;
            hi = 32'sd4094;
        end
        if (sel[SEL_J]) begin
            lo = -32'sd1048576;
            hi = 32'sd1048574;
        end
        if (is_shift(sel, f3)) begin
            lo = 32'sd0;
            hi = 32'sd31;
        end
        if (!$onehot(sel))
            code = 2'd1;
        else if ((sel[SEL_B] || sel[SEL_J]) && imm[0])
            code = 2'd3;
        else if (sel[SEL_U])
            code = (imm[11:0] != 12'd0) ? 2'd2 : 2'd0;
        else if (v < lo || v > hi)
            code = 2'd2;
        return code;
    endfunction

    function automatic logic [31:0] pack_word(input logic [5:0] sel, input logic [4:0] rd,
                                              input logic [4:0] rs1, input logic [4:0] rs2,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] imm);
        logic [31:0] w;
        w = {imm[31:12], rd, OP_U};
        if (sel[SEL_I])
            w = is_shift(sel, f3) ? {f7, imm[4:0], rs1, f3, rd, OP_I}
                                  : {imm[11:0], rs1, f3, rd, OP_I};
        else if (sel[SEL_L])
            w = {imm[11:0], rs1, f3, rd, OP_L};
        else if (sel[SEL_S])
            w = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_S};
        else if (sel[SEL_B])
            w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_B};
        else if (sel[SEL_J])
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_J};
        return w;
    endfunction

    logic        vld_p1;
    logic        vld_p2;
    logic [5:0]  sel_p1;
    logic [4:0]  rd_p1;
    logic [4:0]  rs1_p1;
    logic [4:0]  rs2_p1;
    logic [2:0]  funct3_p1;
    logic [6:0]  funct7_p1;
    logic [31:0] imm_p1;
    logic [1:0]  code_p1;
    logic [5:0]  sel_in;
    logic        accept;
    logic        advance;
    logic        deliver;

    assign sel_in    = {U_type_en, J_type_en, B_type_en, S_type_en, L_type_en, I_type_en};
    assign in_ready  = !vld_p2 || out_ready || !vld_p1;
    assign accept    = in_valid && in_ready;
    assign advance   = vld_p1 && (!vld_p2 || out_ready);
    assign deliver   = vld_p2 && out_ready;
    assign out_valid = vld_p2;

    // Stage 1: capture fields and check result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            vld_p1 <= 1'b0;
        else if (accept)
            vld_p1 <= 1'b1;
        else if (advance)
            vld_p1 <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            sel_p1    <= sel_in;
            rd_p1     <= in_rd;
            rs1_p1    <= in_rs1;
            rs2_p1    <= in_rs2;
            funct3_p1 <= in_funct3;
            funct7_p1 <= in_funct7;
            imm_p1    <= in_imm;
            code_p1   <= check_fields(sel_in, in_funct3, in_imm);
        end
    end

    // Stage 2: packed word, held while downstream stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p2   <= 1'b0;
            instr    <= 32'd0;
            err      <= 1'b0;
            err_code <= 2'd0;
        end else if (advance) begin
            vld_p2   <= 1'b1;
            err_code <= code_p1;
            err      <= (code_p1 != 2'd0);
            instr    <= (code_p1 != 2'd0) ? NOP_WORD
                        : pack_word(sel_p1, rd_p1, rs1_p1, rs2_p1, funct3_p1, funct7_p1, imm_p1);
        end else if (deliver) begin
            vld_p2 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_count <= 16'd0;
            err_count   <= 16'd0;
        end else if (deliver) begin
            instr_count <= instr_count + 16'd1;
            if (err && err_count != 16'hFFFF)
                err_count <= err_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_rv32i_imm_encoder.sv
// Bench for rv32i_imm_encoder: directed vector table, hand-written pipeline sequences,
// and randomized traffic scored against an arithmetic reference model.
module tb_rv32i_imm_encoder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [5:0]  sel;  // [0]=I [1]=L [2]=S [3]=B [4]=J [5]=U
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic [1:0]  exp_code;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  sel = 6'd0;
    logic [4:0]  rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]  f3 = 3'd0;
    logic [6:0]  f7 = 7'd0;
    logic [31:0] imm = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] instr;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] instr_count;
    logic [15:0] err_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [33:0] exp_q[$];
    int          dq[$];
    bit          saw_in_ready_low = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_instr;
    logic [1:0]  prev_code;
    bit          rnd_done = 0;

    rv32i_imm_encoder #(.NOP_WORD(NOP)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .I_type_en(sel[0]), .L_type_en(sel[1]), .S_type_en(sel[2]),
        .B_type_en(sel[3]), .J_type_en(sel[4]), .U_type_en(sel[5]),
        .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_funct3(f3), .in_funct7(f7),
        .in_imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
        .err(err), .err_code(err_code), .instr_count(instr_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic longint fld(input longint u, input int hi, input int lo);
        return (u >> lo) % (longint'(1) << (hi - lo + 1));
    endfunction

    // Reference: format rules expressed as integer ranges and bit placement arithmetic.
    function automatic void model(input vec_t v, output logic [31:0] w, output logic [1:0] code);
        longint s, u, r;
        bit     shift;
        s     = longint'($signed(v.imm));
        u     = longint'(v.imm);
        shift = v.sel[0] && (v.f3 == 3'd1 || v.f3 == 3'd5);
        code  = 2'd0;
        if ($countones(v.sel) != 1) code = 2'd1;
        else if ((v.sel[3] || v.sel[4]) && (u % 2 != 0)) code = 2'd3;
        else if (v.sel[0] || v.sel[1] || v.sel[2]) begin
            if (s < (shift ? 0 : -2048) || s > (shift ? 31 : 2047)) code = 2'd2;
        end else if (v.sel[3]) begin
            if (s < -4096 || s > 4094) code = 2'd2;
        end else if (v.sel[4]) begin
            if (s < -1048576 || s > 1048574) code = 2'd2;
        end else if (u % 4096 != 0) code = 2'd2;

        r = 0;
        if (v.sel[0] || v.sel[1])
            r = (v.sel[0] ? 19 : 3) + (longint'(v.rd) << 7) + (longint'(v.f3) << 12)
                + (longint'(v.rs1) << 15)
                + (shift ? ((fld(u, 4, 0) << 20) + (longint'(v.f7) << 25)) : (fld(u, 11, 0) << 20));
        else if (v.sel[2])
            r = 35 + (fld(u, 4, 0) << 7) + (longint'(v.f3) << 12) + (longint'(v.rs1) << 15)
                + (longint'(v.rs2) << 20) + (fld(u, 11, 5) << 25);
        else if (v.sel[3])
            r = 99 + (fld(u, 11, 11) << 7) + (fld(u, 4, 1) << 8) + (longint'(v.f3) << 12)
                + (longint'(v.rs1) << 15) + (longint'(v.rs2) << 20) + (fld(u, 10, 5) << 25)
                + (fld(u, 12, 12) << 31);
        else if (v.sel[4])
            r = 111 + (longint'(v.rd) << 7) + (fld(u, 19, 12) << 12) + (fld(u, 11, 11) << 20)
                + (fld(u, 10, 1) << 21) + (fld(u, 20, 20) << 31);
        else
            r = 55 + (longint'(v.rd) << 7) + ((u / 4096) * 4096);
        w = (code != 2'd0) ? NOP : r[31:0];
    endfunction

    // Scoreboard and stall-stability observer
    always @(negedge clk) begin
        logic [33:0] e;
        cyc++;
        if (reset_n && prev_stall) begin
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_instr", instr, prev_instr);
            chk("stall_code", {30'd0, err_code}, {30'd0, prev_code});
        end
        if (reset_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", instr);
            end else begin
                e = exp_q.pop_front();
                chk("instr", instr, e[31:0]);
                chk("err_code", {30'd0, err_code}, {30'd0, e[33:32]});
                chk("err", {31'd0, err}, {31'd0, e[33:32] != 2'd0});
            end
            dq.push_back(cyc);
        end
        if (!in_ready) saw_in_ready_low = 1;
        prev_stall = reset_n && out_valid && !out_ready;
        prev_instr = instr;
        prev_code  = err_code;
    end

    task automatic drive(input vec_t v);
        sel = v.sel; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
        f3 = v.f3; f7 = v.f7; imm = v.imm;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input vec_t v);
        bit acc;
        int budget;
        budget = 0;
        drive(v);
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            budget++;
            if (budget > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=stalled required=accept");
                break;
            end
        end
        if (acc) exp_q.push_back({v.exp_code, v.exp_instr});
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkvec(input logic [5:0] s, input logic [4:0] d, input logic [4:0] a,
                                   input logic [4:0] b, input logic [2:0] f, input logic [6:0] g,
                                   input logic [31:0] i);
        vec_t v;
        v.sel = s; v.rd = d; v.rs1 = a; v.rs2 = b; v.f3 = f; v.f7 = g; v.imm = i;
        model(v, v.exp_instr, v.exp_code);
        return v;
    endfunction

    // addi x1, x2, -1 with latency observation; expects idle pipeline, out_ready=1.
    task automatic addi_latency(input string tag);
        vec_t v;
        v.sel = 6'b000001; v.rd = 5'd1; v.rs1 = 5'd2; v.rs2 = 5'd0; v.f3 = 3'd0; v.f7 = 7'd0;
        v.imm = 32'hFFFF_FFFF; v.exp_instr = 32'hFFF1_0093; v.exp_code = 2'd0;
        drive(v);
        in_valid = 1'b1;
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);  // accept edge
        #1;
        exp_q.push_back({v.exp_code, v.exp_instr});
        in_valid = 1'b0;
        chk({tag, "_not_yet"}, {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_instr"}, instr, 32'hFFF1_0093);
        chk({tag, "_err"}, {31'd0, err}, 32'd0);
        drain();
    endtask

    function automatic vec_t rand_vec(input bit legal);
        vec_t v;
        int   t;
        int   bnd[16];
        bnd = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096,
                -1048577, -1048576, 1048574, 1048576, 31, 32, -1};
        t = $urandom_range(0, 5);
        v.sel = 6'd1 << t;
        v.rd = 5'($urandom); v.rs1 = 5'($urandom); v.rs2 = 5'($urandom);
        v.f3 = 3'($urandom); v.f7 = 7'($urandom);
        if (legal) begin
            case (t)
                0, 1, 2: v.imm = (t == 0 && (v.f3 == 3'd1 || v.f3 == 3'd5))
                                 ? $urandom_range(0, 31) : 32'($urandom_range(0, 4095) - 2048);
                3:       v.imm = 32'(($urandom_range(0, 4095) - 2048) * 2);
                4:       v.imm = 32'(($urandom_range(0, 1048575) - 524288) * 2);
                default: v.imm = $urandom & 32'hFFFF_F000;
            endcase
        end else begin
            if ($urandom_range(0, 7) == 0) v.sel = 6'($urandom);
            case ($urandom_range(0, 2))
                0:       v.imm = 32'(bnd[$urandom_range(0, 15)]);
                1:       v.imm = 32'($urandom_range(0, 8191) - 4096);
                default: v.imm = $urandom;
            endcase
        end
        model(v, v.exp_instr, v.exp_code);
        return v;
    endfunction

    initial begin
        vec_t tbl[11];
        vec_t v;
        int   n_err;
        int   base_i, base_e;

        tbl[0]  = '{6'b000100, 5'd0, 5'd6, 5'd5, 3'd2, 7'd0, 32'd8,          32'h0053_2423, 2'd0};
        tbl[1]  = '{6'b001000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC,  32'hFE20_8EE3, 2'd0};
        tbl[2]  = '{6'b010000, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,       32'h0010_00EF, 2'd0};
        tbl[3]  = '{6'b100000, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,  32'h1234_51B7, 2'd0};
        tbl[4]  = '{6'b000001, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048,       NOP,           2'd2};
        tbl[5]  = '{6'b001000, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3,          NOP,           2'd3};
        tbl[6]  = '{6'b100000, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001,  NOP,           2'd2};
        tbl[7]  = '{6'b000000, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,          NOP,           2'd1};
        tbl[8]  = '{6'b100001, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,          NOP,           2'd1};
        tbl[9]  = '{6'b000001, 5'd4, 5'd4, 5'd0, 3'd5, 7'b0100000, 32'd3,    32'h4032_5213, 2'd0};
        tbl[10] = '{6'b000001, 5'd4, 5'd4, 5'd0, 3'd5, 7'b0100000, 32'd32,   NOP,           2'd2};

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);
        chk("rst_instr_count", {16'd0, instr_count}, 32'd0);
        chk("rst_err_count", {16'd0, err_count}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b1;

        addi_latency("addi");

        // Directed table, back to back
        base_i = instr_count;
        base_e = err_count;
        dq.delete();
        n_err = 0;
        foreach (tbl[k]) begin
            send(tbl[k]);
            if (tbl[k].exp_code != 2'd0) n_err++;
        end
        drain();
        chk("table_deliveries", dq.size(), 11);
        for (int k = 1; k < dq.size(); k++)
            chk("back_to_back", dq[k] - dq[k-1], 1);
        chk("table_instr_count", instr_count - 16'(base_i), 11);
        chk("table_err_count", err_count - 16'(base_e), n_err);

        // Backpressure in the middle of a 5-word stream
        base_i = instr_count;
        saw_in_ready_low = 0;
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    v = rand_vec(1'b1);
                    send(v);
                end
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_dropped", {31'd0, saw_in_ready_low}, 32'd1);
        chk("bp_delivered", instr_count - 16'(base_i), 5);

        // Reset with both stages full
        out_ready = 1'b0;
        send(rand_vec(1'b1));
        send(rand_vec(1'b1));
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_instr_count", {16'd0, instr_count}, 32'd0);
        chk("mid_rst_err_count", {16'd0, err_count}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        #10 reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        addi_latency("post_rst");
        chk("post_rst_instr_count", {16'd0, instr_count}, 32'd1);

        // Randomized traffic with random backpressure
        n_err = 0;
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    v = rand_vec($urandom_range(0, 3) == 0);
                    if (v.exp_code != 2'd0) n_err++;
                    send(v);
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk("rnd_instr_count", {16'd0, instr_count}, 32'd301);
        chk("rnd_err_count", {16'd0, err_count}, n_err);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
